// File: rtl/data_route_pkg.sv
// rtl/data_route_pkg.sv - shared widths and constants for the route/DMA data path
//
// Purpose: common parameters for the 1536-bit route side and the 128-bit DMA
// side, plus the holding-register state type used by the down-converter.
// Ports: none (package).
package data_route_pkg;

  localparam int DMA_WIDTH   = 128;
  localparam int ROUTE_WIDTH = 1536;
  localparam int SLICES      = ROUTE_WIDTH / DMA_WIDTH;
  localparam int FRAME_LEN_W = 24;

  localparam logic [DMA_WIDTH/8-1:0] KEEP_ALL = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/axis_frame_counter.sv
// rtl/axis_frame_counter.sv - output-beat framing: tlast, frame_done, frame_cnt
//
// Purpose: counts handshaked output beats against a programmable frame length
// and reports frame boundaries. Width-agnostic, so it can sit behind any
// stream width.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   soft_clr_i      synchronous flush of beat count and latched length
//   frame_beats_i   beats per frame, 0 = unframed stream
//   beat_hs_i       one output beat handshaked this cycle
//   tlast_now_o     the current beat is the last of its frame
//   frame_done_o    one-cycle pulse after a tlast handshake
//   frame_cnt_o     completed frames, wraps
//   mid_frame_o     beat counter is non-zero
module axis_frame_counter
  import data_route_pkg::*;
#(
  parameter int LEN_W = FRAME_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr_i,
  input  logic [LEN_W-1:0] frame_beats_i,
  input  logic             beat_hs_i,
  output logic             tlast_now_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o,
  output logic             mid_frame_o
);

  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_eff;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // On the first beat of a frame the length is not latched yet, so it is taken
  // live; this lets a one-beat frame end on its very first beat.
  assign len_eff     = (beat_cnt_q == '0) ? frame_beats_i : len_q;
  assign tlast_now_o = (len_eff != '0) && (beat_cnt_q == len_eff - LEN_W'(1));

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (soft_clr_i) begin
      beat_cnt_d = '0;
      len_d      = '0;
    end else if (beat_hs_i) begin
      if (beat_cnt_q == '0) begin
        len_d = frame_beats_i;
      end
      if (tlast_now_o) begin
        beat_cnt_d   = '0;
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
      end else if (beat_cnt_q != '1) begin
        // Saturation only matters in stream mode, where no tlast ever resets it.
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      len_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign mid_frame_o  = (beat_cnt_q != '0);

endmodule

// File: rtl/axis_1536to128_framer.sv
// rtl/axis_1536to128_framer.sv - 1536-bit to 128-bit stream down-converter with framing
//
// Purpose: holds one wide input word and emits it as RATIO narrow beats, LSB
// slice first, with tlast/tkeep framing from a programmable beat count.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_beats           output beats per frame, 0 = unframed stream
//   soft_clr              synchronous flush pulse
//   s_axis_t*             wide input stream (tdata/tvalid/tready)
//   m_axis_t*             narrow output stream (tdata/tvalid/tready/tkeep/tlast)
//   frame_done            one-cycle pulse after each tlast handshake
//   frame_cnt             completed frames, wraps
//   busy                  holding a word or mid-frame
module axis_1536to128_framer
  import data_route_pkg::*;
#(
  parameter int IN_WIDTH  = ROUTE_WIDTH,
  parameter int OUT_WIDTH = DMA_WIDTH,
  parameter int LEN_W     = FRAME_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LEN_W-1:0]       frame_beats,
  input  logic                   soft_clr,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic                   busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  hold_state_e                         state_q, state_d;
  logic [IN_WIDTH-1:0]                 word_q, word_d;
  logic [IDX_W-1:0]                    slice_idx_q, slice_idx_d;
  logic                                out_of_reset_q;
  logic [RATIO-1:0][OUT_WIDTH-1:0]     word_slices;
  logic                                full, in_hs, out_hs, final_slice;
  logic                                tlast_now, mid_frame;

  assign in_hs       = s_axis_tvalid && s_axis_tready;
  assign out_hs      = m_axis_tvalid && m_axis_tready;
  // A tlast mid-word ends the word early: its remaining slices are dropped.
  assign final_slice = (slice_idx_q == IDX_W'(RATIO - 1)) || tlast_now;

  // State register. out_of_reset_q keeps s_axis_tready low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      word_q         <= '0;
      slice_idx_q    <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      slice_idx_q    <= slice_idx_d;
      out_of_reset_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    slice_idx_d = slice_idx_q;
    if (in_hs) begin
      word_d = s_axis_tdata;
    end
    if (soft_clr) begin
      state_d     = EMPTY;
      slice_idx_d = '0;
    end else begin
      case (state_q)
        EMPTY:   if (in_hs) state_d = HOLD;
        HOLD:    if (out_hs && final_slice && !in_hs) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
      if (out_hs) begin
        slice_idx_d = final_slice ? '0 : slice_idx_q + IDX_W'(1);
      end
    end
  end

  // Output logic. Ready opens on the final slice so a new word reloads
  // without a bubble.
  always_comb begin
    full          = (state_q == HOLD);
    m_axis_tvalid = full;
    s_axis_tready = out_of_reset_q && !soft_clr &&
                    (!full || (m_axis_tready && final_slice));
  end

  assign word_slices  = word_q;
  assign m_axis_tdata = word_slices[slice_idx_q];
  assign m_axis_tlast = tlast_now && full;
  assign m_axis_tkeep = KEEP_ALL;
  assign busy         = full || mid_frame;

  axis_frame_counter #(
    .LEN_W(LEN_W)
  ) u_frame_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_clr_i   (soft_clr),
    .frame_beats_i(frame_beats),
    .beat_hs_i    (out_hs),
    .tlast_now_o  (tlast_now),
    .frame_done_o (frame_done),
    .frame_cnt_o  (frame_cnt),
    .mid_frame_o  (mid_frame)
  );

endmodule

// File: tb/tb_axis_1536to128_framer.sv
// tb/tb_axis_1536to128_framer.sv - self-checking bench for axis_1536to128_framer
module tb_axis_1536to128_framer;

  localparam int IW = 1536;
  localparam int OW = 128;
  localparam int LW = 24;
  localparam int NS = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] frame_beats = '0;
  logic          soft_clr = 1'b0;
  logic [IW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [15:0]   m_axis_tkeep;
  logic          m_axis_tlast;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          busy;

  axis_1536to128_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_beats  (frame_beats),
    .soft_clr     (soft_clr),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    bit            last;
    bit            fin;
  } beat_t;

  int            n_checks = 0;
  int            n_pass = 0;
  beat_t         exp_q[$];
  logic [IW-1:0] words[$];
  int            cnt_exp = 0;
  int            model_bcnt = 0;
  int            widx = 0;
  int            vpct_g = 100;
  int            rpct_g = 100;
  int            cyc_g = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [IW-1:0] make_word(input int n, input bit pat);
    logic [IW-1:0] w;
    w = '0;
    for (int k = 0; k < NS; k++) begin
      logic [OW-1:0] s;
      logic [7:0]    b;
      b = 8'(n * NS + k);
      if (pat) s = {16{b}};
      else     s = {$urandom, $urandom, $urandom, $urandom};
      w[k*OW +: OW] = s;
    end
    return w;
  endfunction

  // Expected beat stream: slices in order, frame boundary every len beats,
  // and a boundary drops the rest of the word it lands in.
  task automatic build_model(input int len);
    exp_q.delete();
    model_bcnt = 0;
    foreach (words[w]) begin
      for (int k = 0; k < NS; k++) begin
        beat_t b;
        b.data = words[w][k*OW +: OW];
        b.last = (len != 0) && (model_bcnt == len - 1);
        b.fin  = b.last || (k == NS - 1);
        exp_q.push_back(b);
        if (b.last) begin
          model_bcnt = 0;
          break;
        end
        model_bcnt++;
      end
    end
  endtask

  task automatic drive_inputs();
    if (!s_axis_tvalid && widx < words.size() && $urandom_range(99) < vpct_g) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[widx];
    end
    if (rpct_g < 0) m_axis_tready = ((cyc_g % 4) == 0) || ((cyc_g % 4) == 3);
    else            m_axis_tready = ($urandom_range(99) < rpct_g);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_tkeep"}, m_axis_tkeep, 16'hFFFF);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    soft_clr = 1'b0;
    #3;
    check_reset_values(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cnt_exp = 0;
  endtask

  // Runs nw words through the DUT; stop_at >= 0 returns right after that many
  // output beats have handshaked.
  task automatic run(input int nw, input int len, input bit pat, input int vpct,
                     input int rpct, input int stop_at);
    int beats = 0;
    bit tail = 0;
    bit done_exp = 0;
    bit finished = 0;
    bit in_acc;
    bit no_gap;
    no_gap = (vpct >= 100) && (rpct >= 100);
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back(make_word(i, pat));
    build_model(len);
    frame_beats = LW'(len);
    widx = 0;
    vpct_g = vpct;
    rpct_g = rpct;
    cyc_g = 0;
    drive_inputs();
    for (cyc_g = 0; cyc_g < 4000; cyc_g++) begin
      @(negedge clk);
      check("frame_done", frame_done, done_exp);
      check("frame_cnt", frame_cnt, 16'(cnt_exp));
      check("tkeep", m_axis_tkeep, 16'hFFFF);
      done_exp = 0;
      if (no_gap && beats > 0 && exp_q.size() > 0) check("no_bubble", m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        check("valid_has_beat", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("tdata", m_axis_tdata, exp_q[0].data);
          check("tlast", m_axis_tlast, exp_q[0].last);
          check("s_tready_hold", s_axis_tready, m_axis_tready && exp_q[0].fin);
          if (m_axis_tready) begin
            done_exp = exp_q[0].last;
            if (done_exp) cnt_exp++;
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end else begin
        check("s_tready_empty", s_axis_tready, 1);
      end
      in_acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (in_acc) begin
        s_axis_tvalid = 1'b0;
        widx++;
      end
      if (stop_at >= 0 && beats >= stop_at) begin
        finished = 1;
        break;
      end
      if (widx >= words.size() && exp_q.size() == 0) begin
        if (tail) begin
          finished = 1;
          break;
        end
        tail = 1;
      end
      drive_inputs();
    end
    check("run_finished", finished, 1);
    if (stop_at < 0 && finished) begin
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      check("busy_end", busy, model_bcnt != 0);
    end
  endtask

  initial begin
    int lens[6];
    lens = '{0, 1, 5, 12, 13, 30};

    do_reset("reset0");

    // Two words, one 24-beat frame, no backpressure.
    run(2, 24, 1, 100, 100, -1);
    // Same, with ready pattern 1,0,0,1.
    do_reset("reset1");
    run(2, 24, 1, 100, -1, -1);
    // 18-beat frames: second word is cut after slice 5.
    do_reset("reset2");
    run(3, 18, 1, 100, 100, -1);
    // Stream mode, continuous supply.
    do_reset("reset3");
    run(4, 0, 1, 100, 100, -1);
    check("stream_frame_cnt", frame_cnt, 0);

    // Reset mid-frame at beat 7, then a fresh 12-beat frame.
    do_reset("reset4");
    run(2, 24, 1, 100, 100, 7);
    do_reset("midframe_rst");
    run(1, 12, 1, 100, 100, -1);
    check("after_rst_frames", frame_cnt, 1);

    // soft_clr at beat 5 of the fourth frame.
    do_reset("reset5");
    run(3, 12, 1, 100, 100, -1);
    run(2, 12, 1, 100, 100, 5);
    soft_clr = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check("soft_clr_s_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    soft_clr = 1'b0;
    @(negedge clk);
    check("soft_clr_tvalid", m_axis_tvalid, 0);
    check("soft_clr_frame_cnt", frame_cnt, 3);
    check("soft_clr_busy", busy, 0);
    @(posedge clk); #1;
    run(1, 12, 1, 100, 100, -1);

    // Randomized data, lengths and handshake rates.
    for (int t = 0; t < 6; t++) begin
      do_reset("reset_rand");
      run(4 + int'($urandom_range(3)), lens[t], 0,
          30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
